// File: rtl/sect163r2_pt_mul_req.sv
// Request/response sequencer for the sect163r2_pt_mul core: one scalar in, one (x,y) out.
// Define SECT163R2_PT_MUL_REQ_ZERO_BYPASS_EN to answer d==0 directly with the point at infinity.
module sect163r2_pt_mul_req #(
    parameter int LatW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [162:0]    req_d,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [162:0]    rsp_x,
    output logic [162:0]    rsp_y,
    output logic [LatW-1:0] lat,
    output logic            busy,
    output logic            core_clr,
    output logic            core_start,
    output logic [162:0]    core_d,
    input  logic            core_done,
    input  logic [162:0]    core_x,
    input  logic [162:0]    core_y
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [162:0]    d_q, d_d;
    logic [162:0]    rsp_x_q, rsp_x_d;
    logic [162:0]    rsp_y_q, rsp_y_d;
    logic [LatW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [LatW-1:0] lat_q, lat_d;
    logic            done_q;
    logic            done_edge;
    logic            rsp_valid_q, core_start_q, busy_q;

    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + LatW'(1);
    assign done_edge = core_done && !done_q;

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        rsp_x_d = rsp_x_q;
        rsp_y_d = rsp_y_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    d_d     = req_d;
                    state_d = S_START;
`ifdef SECT163R2_PT_MUL_REQ_ZERO_BYPASS_EN
                    if (req_d == '0) begin
                        state_d = S_RESP;
                        rsp_x_d = '0;
                        rsp_y_d = '0;
                        lat_d   = '0;
                    end
`endif
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                // lat counts BUSY cycles including the edge cycle, hence the incremented value.
                cnt_d = cnt_inc;
                if (done_edge) begin
                    rsp_x_d = core_x;
                    rsp_y_d = core_y;
                    lat_d   = cnt_inc;
                    state_d = S_RESP;
                end
            end
            default: begin
                if (rsp_ready) state_d = S_IDLE;
            end
        endcase
        if (clr) begin
            state_d = S_IDLE;
            d_d     = '0;
            rsp_x_d = '0;
            rsp_y_d = '0;
            lat_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            d_q          <= '0;
            rsp_x_q      <= '0;
            rsp_y_q      <= '0;
            cnt_q        <= '0;
            lat_q        <= '0;
            done_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_q          <= d_d;
            rsp_x_q      <= rsp_x_d;
            rsp_y_q      <= rsp_y_d;
            cnt_q        <= cnt_d;
            lat_q        <= lat_d;
            done_q       <= core_done;
            rsp_valid_q  <= (state_d == S_RESP);
            core_start_q <= (state_d == S_START);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign core_d     = (state_q == S_START) ? d_q : '0;
    assign core_clr   = clr;
    assign core_start = core_start_q;
    assign rsp_valid  = rsp_valid_q;
    assign busy       = busy_q;
    assign rsp_x      = rsp_x_q;
    assign rsp_y      = rsp_y_q;
    assign lat        = lat_q;

endmodule

// File: tb/tb_sect163r2_pt_mul_req.sv
// Directed bench for sect163r2_pt_mul_req with a behavioural stub core.
// Honours SECT163R2_PT_MUL_REQ_ZERO_BYPASS_EN for the zero-scalar step.
module tb_sect163r2_pt_mul_req;

    localparam int LatW = 16;
    localparam logic [162:0] GX = 163'h3f0eba16286a2d57ea0991168d4994637e8343e36;
    localparam logic [162:0] GY = 163'h0d51fbc6c71a0094fa2cdd545b11c5c0c797324f1;
    localparam logic [162:0] KX = 163'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            clr = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [162:0]    req_d = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [162:0]    rsp_x, rsp_y;
    logic [LatW-1:0] lat;
    logic            busy, core_clr, core_start;
    logic [162:0]    core_d;
    logic            core_done = 1'b0;
    logic [162:0]    core_x = '0, core_y = '0;

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;
    int stub_lat = 5;
    bit stub_hold = 1'b0;
    int tmr = 0;
    logic [162:0] stub_d = '0;

    sect163r2_pt_mul_req #(.LatW(LatW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_d(req_d),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_x(rsp_x), .rsp_y(rsp_y),
        .lat(lat), .busy(busy), .core_clr(core_clr), .core_start(core_start),
        .core_d(core_d), .core_done(core_done), .core_x(core_x), .core_y(core_y)
    );

    always #5 clk = ~clk;

    function automatic logic [162:0] exp_x(input logic [162:0] d);
        if (d == 163'd1) return GX;
        return {d[80:0], d[162:81]} ^ KX;
    endfunction

    function automatic logic [162:0] exp_y(input logic [162:0] d);
        if (d == 163'd1) return GY;
        return ~d;
    endfunction

    // Stub core: done stays high after a result; start clears it unless stub_hold is set.
    always @(posedge clk) begin
        if (core_start) begin
            n_start <= n_start + 1;
            tmr     <= stub_lat;
            stub_d  <= core_d;
            if (!stub_hold) core_done <= 1'b0;
        end else if (tmr != 0) begin
            tmr <= tmr - 1;
            if (tmr == 1) begin
                core_done <= 1'b1;
                core_x    <= exp_x(stub_d);
                core_y    <= exp_y(stub_d);
            end else begin
                core_done <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [162:0] obs, input logic [162:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            step();
            n++;
        end
        check(tag, 163'(rsp_valid), 163'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    logic [162:0] vecs [6];
    logic [162:0] x0, y0;
    int  s0;
    bit  seen;

    initial begin
        vecs[0] = 163'd1;
        vecs[1] = 163'd2;
        vecs[2] = {163{1'b1}};
        vecs[3] = 163'h40000000000000000000000000000000000000001;
        vecs[4] = 163'h123456789abcdef0123456789abcdef012345678;
        vecs[5] = 163'd1;

        #1 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 163'(req_ready), 163'd1);
        check("rst_rsp_valid", 163'(rsp_valid), 163'd0);
        check("rst_core_start", 163'(core_start), 163'd0);
        check("rst_busy", 163'(busy), 163'd0);
        check("rst_core_d", core_d, '0);
        check("rst_rsp_x", rsp_x, '0);
        check("rst_rsp_y", rsp_y, '0);
        check("rst_lat", 163'(lat), '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic d=1 transaction; cycle 0 is the handshake.
        stub_lat  = 5;
        req_d     = 163'd1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("c1_core_start", 163'(core_start), 163'd1);
        check("c1_core_d", core_d, 163'd1);
        check("c1_req_ready", 163'(req_ready), 163'd0);
        step();
        check("c2_core_start", 163'(core_start), 163'd0);
        check("c2_core_d", core_d, '0);
        wait_rsp("g_rsp_valid", 200);
        check("g_rsp_x", rsp_x, GX);
        check("g_rsp_y", rsp_y, GY);
        check("g_lat", 163'(lat), 163'd6);
        check("g_starts", 163'(n_start), 163'd1);

        // Response back-pressure for 20 cycles.
        x0 = rsp_x;
        y0 = rsp_y;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!rsp_valid || req_ready || rsp_x !== x0 || rsp_y !== y0) seen = 1'b1;
        end
        check("stall_stable", 163'(seen), 163'd0);
        take_rsp();
        check("pulse_req_ready", 163'(req_ready), 163'd1);
        check("pulse_rsp_valid", 163'(rsp_valid), 163'd0);

        // done already high across start: only the second rising edge counts.
        stub_hold = 1'b1;
        stub_lat  = 49;
        req_d     = 163'd5;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("hold_no_early", 163'(rsp_valid), 163'd0);
        wait_rsp("hold_rsp_valid", 200);
        check("hold_lat", 163'(lat), 163'd50);
        check("hold_rsp_x", rsp_x, exp_x(163'd5));
        take_rsp();
        stub_hold = 1'b0;

        // Back-to-back stream with req_valid and rsp_ready tied high.
        s0 = n_start;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_d     = vecs[i];
            stub_lat  = 1 + 3 * i;
            req_valid = 1'b1;
            step();
            wait_rsp("strm_rsp_valid", 200);
            check("strm_rsp_x", rsp_x, exp_x(vecs[i]));
            check("strm_rsp_y", rsp_y, exp_y(vecs[i]));
            check("strm_lat", 163'(lat), 163'(stub_lat + 1));
            if (i == 5) req_valid = 1'b0;
        end
        step();
        rsp_ready = 1'b0;
        check("strm_starts", 163'(n_start - s0), 163'd6);

        // Zero scalar.
        s0 = n_start;
        stub_lat  = 3;
        req_d     = '0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
`ifdef SECT163R2_PT_MUL_REQ_ZERO_BYPASS_EN
        check("zero_rsp_valid", 163'(rsp_valid), 163'd1);
        check("zero_rsp_x", rsp_x, '0);
        check("zero_rsp_y", rsp_y, '0);
        check("zero_lat", 163'(lat), '0);
        check("zero_core_start", 163'(core_start), 163'd0);
        take_rsp();
        check("zero_starts", 163'(n_start - s0), 163'd0);
`else
        check("zero_core_start", 163'(core_start), 163'd1);
        check("zero_core_d", core_d, '0);
        wait_rsp("zero_rsp_valid", 200);
        check("zero_rsp_x", rsp_x, exp_x('0));
        take_rsp();
        check("zero_starts", 163'(n_start - s0), 163'd1);
`endif

        // clr during BUSY, then a late done edge must be ignored.
        stub_lat  = 10;
        req_d     = 163'd7;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        clr = 1'b1;
        #1;
        check("clr_core_clr", 163'(core_clr), 163'd1);
        check("clr_busy_before", 163'(busy), 163'd1);
        @(negedge clk);
        clr = 1'b0;
        check("clr_req_ready", 163'(req_ready), 163'd1);
        check("clr_busy", 163'(busy), 163'd0);
        check("clr_rsp_x", rsp_x, '0);
        check("clr_lat", 163'(lat), '0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid || busy) seen = 1'b1;
        end
        check("clr_late_done", 163'(seen), 163'd0);

        // clr wins over a simultaneous request handshake.
        req_d     = 163'd9;
        req_valid = 1'b1;
        clr       = 1'b1;
        step();
        req_valid = 1'b0;
        clr       = 1'b0;
        check("clr_drop_start", 163'(core_start), 163'd0);
        check("clr_drop_busy", 163'(busy), 163'd0);

        // Asynchronous reset in the middle of an operation.
        stub_lat  = 20;
        req_d     = 163'd3;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 163'(busy), 163'd0);
        check("arst_req_ready", 163'(req_ready), 163'd1);
        check("arst_core_start", 163'(core_start), 163'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
